// File: rtl/encoder_p_16x4_req.sv
// Registered 16-to-4 priority encoder with a pending-request register and a
// valid/ready issue handshake. Request pulses accumulate in the pending
// register, one index is presented at a time, and a bit is cleared once its
// index is accepted.
// Optional: define ENCODER_P_ROUND_ROBIN_EN to select round-robin search
// (downward from last_granted - 1, wrapping 0 -> 15) instead of fixed
// highest-index priority.
module encoder_p_16x4_req #(
  parameter int unsigned CODE_LENGTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [(2**CODE_LENGTH)-1:0]   req_i,
  input  logic                          enable_i,
  input  logic                          ready_i,
  output logic [CODE_LENGTH-1:0]        code_o,
  output logic                          valid_o,
  output logic [(2**CODE_LENGTH)-1:0]   pending_o,
  output logic                          busy_o
);

  localparam int unsigned INPUT_WIDTH = 2 ** CODE_LENGTH;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t                   state, state_next;
  logic [INPUT_WIDTH-1:0]   pending, pending_next;
  logic [INPUT_WIDTH-1:0]   clr;
  logic [CODE_LENGTH-1:0]   code_next;
  logic                     valid_next;
  logic [CODE_LENGTH-1:0]   sel;
  logic                     accept;

  assign accept = valid_o & ready_i;

  // Clear the accepted bit; a same-cycle request for that bit re-queues it.
  always_comb begin
    clr = '0;
    if (accept) clr = INPUT_WIDTH'(1) << code_o;
    pending_next = (pending & ~clr) | req_i;
  end

`ifdef ENCODER_P_ROUND_ROBIN_EN
  logic [CODE_LENGTH-1:0] last_granted;
  logic [CODE_LENGTH-1:0] start_idx;
  logic [CODE_LENGTH-1:0] idx;
  logic                   found;

  assign start_idx = last_granted - CODE_LENGTH'(1);

  // Round-robin search: walk downward from start_idx with wrap, first hit wins.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
      idx = start_idx - CODE_LENGTH'(i);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer records the most recently accepted index.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     last_granted <= '0;
    else if (accept) last_granted <= code_o;
  end
`else
  // Fixed priority: later (higher) indices overwrite, so the highest set bit wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
      if (pending[i]) sel = CODE_LENGTH'(i);
    end
  end
`endif

  // Next-state and output logic for the issue handshake.
  always_comb begin
    state_next = state;
    code_next  = code_o;
    valid_next = valid_o;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (enable_i && (pending != '0)) begin
          code_next  = sel;
          valid_next = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (ready_i) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, presented code and pending register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      code_o  <= '0;
      valid_o <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_next;
      code_o  <= code_next;
      valid_o <= valid_next;
      pending <= pending_next;
    end
  end

  assign pending_o = pending;
  assign busy_o    = (pending != '0) || valid_o;

endmodule

// File: tb/tb_encoder_p_16x4_req.sv
// Directed bench for encoder_p_16x4_req with hand-computed expectations.
module tb_encoder_p_16x4_req;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [15:0] req_i = '0;
  logic        enable_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [3:0]  code_o;
  logic        valid_o;
  logic [15:0] pending_o;
  logic        busy_o;

  int unsigned total = 0;
  int unsigned bad = 0;

  encoder_p_16x4_req #(.CODE_LENGTH(4)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .enable_i  (enable_i),
    .ready_i   (ready_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .pending_o (pending_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #3;
    reset_i = 1'b0;
  endtask

  // Expect a presented code (valid high) or an idle bubble.
  task automatic expect_code(input string tag, input logic [3:0] c);
    check({tag, "_valid"}, 16'(valid_o), 16'h1);
    check({tag, "_code"}, 16'(code_o), 16'(c));
  endtask

  initial begin
    // Reset then idle
    #2;
    do_reset();
    check("rst_valid", 16'(valid_o), 16'h0);
    check("rst_code", 16'(code_o), 16'h0);
    check("rst_pend", pending_o, 16'h0);
    check("rst_busy", 16'(busy_o), 16'h0);
    tick();
    check("idle_valid", 16'(valid_o), 16'h0);

    // Single request -> code 5, two edges after the pulse
    enable_i = 1'b1;
    ready_i  = 1'b1;
    req_i    = 16'h0020;
    tick();
    req_i = '0;
    check("single_pend", pending_o, 16'h0020);
    check("single_nv", 16'(valid_o), 16'h0);
    check("single_busy", 16'(busy_o), 16'h1);
    tick();
    expect_code("single", 4'd5);
    tick();
    check("single_clr", pending_o, 16'h0);
    check("single_drop", 16'(valid_o), 16'h0);
    check("single_nbusy", 16'(busy_o), 16'h0);

    // Priority order 15, 8, 0 with a bubble between each
    req_i = 16'h8101;
    tick();
    req_i = '0;
    tick();
    expect_code("prio15", 4'd15);
    tick();
    check("prio_b1", 16'(valid_o), 16'h0);
    check("prio_pend1", pending_o, 16'h0101);
    tick();
    expect_code("prio8", 4'd8);
    tick();
    check("prio_b2", 16'(valid_o), 16'h0);
    tick();
    expect_code("prio0", 4'd0);
    tick();
    check("prio_b3", 16'(valid_o), 16'h0);
    check("prio_pend3", pending_o, 16'h0);

    // Backpressure: code 3 held through enable toggles and a new request
    ready_i = 1'b0;
    req_i   = 16'h0008;
    tick();
    req_i = '0;
    tick();
    expect_code("bp0", 4'd3);
    enable_i = 1'b0;
    req_i    = 16'h8000;
    tick();
    req_i = '0;
    expect_code("bp1", 4'd3);
    check("bp_pend", pending_o, 16'h8008);
    enable_i = 1'b1;
    tick();
    expect_code("bp2", 4'd3);
    enable_i = 1'b0;
    tick();
    expect_code("bp3", 4'd3);
    ready_i  = 1'b1;
    enable_i = 1'b1;
    tick();
    check("bp_acc_v", 16'(valid_o), 16'h0);
    check("bp_acc_p", pending_o, 16'h8000);
    tick();
    expect_code("bp15", 4'd15);
    tick();
    check("bp_end", pending_o, 16'h0);

    // Set/clear collision on bit 7
    ready_i = 1'b0;
    req_i   = 16'h0080;
    tick();
    req_i = '0;
    tick();
    expect_code("col0", 4'd7);
    ready_i = 1'b1;
    req_i   = 16'h0080;
    tick();
    req_i   = '0;
    ready_i = 1'b0;
    check("col_pend", pending_o, 16'h0080);
    check("col_v", 16'(valid_o), 16'h0);
    tick();
    expect_code("col1", 4'd7);
    // Async reset mid-PRESENT takes effect without a clock edge
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_valid", 16'(valid_o), 16'h0);
    check("arst_pend", pending_o, 16'h0);
    check("arst_code", 16'(code_o), 16'h0);
    reset_i = 1'b0;
    tick();
    check("arst_stay", 16'(valid_o), 16'h0);

    // Issue-order policy: 8001, bit 15 re-requested on its accept
    ready_i = 1'b0;
    req_i   = 16'h8001;
    tick();
    req_i = '0;
    tick();
    expect_code("pol0", 4'd15);
    ready_i = 1'b1;
    req_i   = 16'h8000;
    tick();
    req_i = '0;
    check("pol_pend", pending_o, 16'h8001);
    tick();
`ifdef ENCODER_P_ROUND_ROBIN_EN
    expect_code("pol1", 4'd0);
`else
    expect_code("pol1", 4'd15);
`endif
    tick();
    tick();
`ifdef ENCODER_P_ROUND_ROBIN_EN
    expect_code("pol2", 4'd15);
`else
    expect_code("pol2", 4'd0);
`endif
    tick();
    check("pol_end", pending_o, 16'h0);

    // Full condition; enable low blocks issue but not capture
    do_reset();
    enable_i = 1'b0;
    req_i    = 16'hFFFF;
    tick();
    req_i = '0;
    tick();
    check("full_pend", pending_o, 16'hFFFF);
    check("full_blk", 16'(valid_o), 16'h0);
    check("full_busy", 16'(busy_o), 16'h1);
    enable_i = 1'b1;
    for (int k = 15; k >= 0; k--) begin
      tick();
      expect_code($sformatf("full%0d", k), 4'(k));
      tick();
      check($sformatf("full_b%0d", k), 16'(valid_o), 16'h0);
    end
    check("full_end", pending_o, 16'h0);
    check("full_nbusy", 16'(busy_o), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_p_16x4_req.md
Name: encoder_p_16x4_req

Overview:
- Registered 16-to-4 priority encoder; inverse of the 4x16 enabled decoder path.
- Collects one-hot/multi-hot request pulses into a pending register and issues one 4-bit index at a time over a valid/ready handshake.
- Clears each bit once its index is accepted; feeds the control unit, which turns request lines back into select codes.

Parameters:
- CODE_LENGTH, 4, width of the issued index.
- INPUT_WIDTH, 2**CODE_LENGTH (16), number of request lines; derived, not overridden independently.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- req_i  input  INPUT_WIDTH  request pulses; any set bit is OR'd into pending each cycle.
- enable_i  input  1  issue enable; low blocks new issues, never blocks capture.
- ready_i  input  1  consumer accepts code_o when high with valid_o.
- code_o  output  CODE_LENGTH  issued index; registered.
- valid_o  output  1  code_o is valid; registered.
- pending_o  output  INPUT_WIDTH  current pending register, for visibility.
- busy_o  output  1  high when pending_o != 0 or valid_o == 1.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - pending = 0, code_o = 0, valid_o = 0, state = IDLE.
  - Round-robin pointer = 0 (feature on).
  - An item presented at reset is dropped.
- Pending update every cycle: pending_next = (pending & ~clr) | req_i.
  - clr = one-hot(code_o) only on an accept cycle (valid_o & ready_i), else 0.
  - If req_i sets the bit being cleared in the same cycle, the set wins; the request is re-queued.
- State machine, two states:
  - IDLE: if enable_i && pending != 0, load code_o = selected index, valid_o <= 1, go to PRESENT. Otherwise hold, valid_o = 0.
  - IDLE selection uses the registered pending only; req_i bits arriving in the same cycle are not eligible until the next cycle.
  - PRESENT: code_o and valid_o hold stable until ready_i = 1, regardless of enable_i or new req_i. On accept: valid_o <= 0, clear the bit, go to IDLE.
- Throughput: one issue per 2 cycles maximum; one bubble cycle after each accept.
- Latency: req_i pulse in cycle N -> pending bit set after edge N -> valid_o high after edge N+1, if IDLE and enable_i high.
- Fixed priority (default): highest set index wins. pending 16'h0000 never issues.
- Index width: code_o is the binary index 0..15; no bounds wrap needed because INPUT_WIDTH = 2**CODE_LENGTH.
- Full condition: all 16 bits pending is legal. Issue order 15, 14, ..., 0; no overflow because repeated requests for a set bit merge.
- enable_i low while PRESENT: the item stays presented and can still be accepted; enable_i only gates the IDLE -> PRESENT transition.

Optional Feature:
- Macro: ENCODER_P_ROUND_ROBIN_EN.
- Defined:
  - Search starts at index (last_granted - 1) mod 16 and proceeds downward with wrap 0 -> 15; the first set bit found wins.
  - last_granted updates on each accept; reset value 0, so the first search starts at 15 and matches fixed priority.
  - Prevents starvation of low indices.
- Undefined: fixed highest-index priority as above; no pointer register exists.

Test Plan:
- Reset then idle: reset_i high then low, req_i = 0 -> valid_o = 0, code_o = 0, pending_o = 0, busy_o = 0.
- Single request, enable_i = 1, ready_i = 1:
  - req_i = 16'h0020 for 1 cycle -> valid_o high 2 edges later with code_o = 4'd5.
  - Accepted the same cycle; pending_o returns to 0 next cycle.
- Priority order, ready_i = 1:
  - req_i = 16'h8101 pulse -> codes 15, 8, 0 issued in order, each valid for 1 cycle, separated by 1 idle cycle.
- Backpressure:
  - ready_i = 0 with code_o = 4'd3 presented; toggle enable_i and pulse req_i = 16'h8000 -> code_o stays 3 and valid_o stays 1 until ready_i = 1.
  - Code 15 then issues next.
- Set/clear collision:
  - Accept code 4'd7 in the same cycle req_i[7] = 1 -> pending_o[7] remains 1 and 7 is issued again.
  - Async reset asserted mid-PRESENT -> valid_o drops immediately, pending_o = 0.
- With ENCODER_P_ROUND_ROBIN_EN: pending 16'h8001, after accepting 15, req_i = 16'h8000 again -> next code is 0, then 15. Without the macro: 15, 15, then 0.
